hex_to_seg: RTL and testbench

Registered hexadecimal-to-seven-segment decoder. Converts a 4-bit nibble (0x0–0xF) into the seven segment-drive bits for a single digit, with digits 0–9 and letters A, b, C, d, E, F. Sits between a value source (counter, register, bus snoop) and the display pin drivers or a digit multiplexer. The output is registered so the pad-facing signals are glitch-free.

---
 rtl/hex_to_seg_pkg.sv | 48 ++++
 rtl/hex_to_seg_lut.sv | 40 ++++
 rtl/hex_to_seg.sv | 44 ++++
 tb/tb_hex_to_seg.sv | 97 +++++++++
 4 files changed

// File: rtl/hex_to_seg_pkg.sv
// hex_to_seg_pkg: active-high seven-segment codes, blank pattern and segment bit indices
package hex_to_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_HEX_A = 7'h77;
    localparam seg_t SEG_HEX_B = 7'h7C;
    localparam seg_t SEG_HEX_C = 7'h39;
    localparam seg_t SEG_HEX_D = 7'h5E;
    localparam seg_t SEG_HEX_E = 7'h79;
    localparam seg_t SEG_HEX_F = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

    // Reorders individual segment states into the {g,f,e,d,c,b,a} bus layout.
    function automatic seg_t seg_pack(input logic a, input logic b, input logic c,
                                      input logic d, input logic e, input logic f,
                                      input logic g);
        seg_t r;
        r        = SEG_BLANK;
        r[SEG_A] = a;
        r[SEG_B] = b;
        r[SEG_C] = c;
        r[SEG_D] = d;
        r[SEG_E] = e;
        r[SEG_F] = f;
        r[SEG_G] = g;
        return r;
    endfunction

endpackage

// File: rtl/hex_to_seg_lut.sv
// hex_to_seg_lut: combinational nibble-to-segment lookup, active-high output
module hex_to_seg_lut
    import hex_to_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    seg_t raw;

    // Table lookup; all 16 codes are covered, the default arm only guards X inputs.
    always_comb begin
        case (hex)
            4'h0:    raw = SEG_0;
            4'h1:    raw = SEG_1;
            4'h2:    raw = SEG_2;
            4'h3:    raw = SEG_3;
            4'h4:    raw = SEG_4;
            4'h5:    raw = SEG_5;
            4'h6:    raw = SEG_6;
            4'h7:    raw = SEG_7;
            4'h8:    raw = SEG_8;
            4'h9:    raw = SEG_9;
            4'hA:    raw = SEG_HEX_A;
            4'hB:    raw = SEG_HEX_B;
            4'hC:    raw = SEG_HEX_C;
            4'hD:    raw = SEG_HEX_D;
            4'hE:    raw = SEG_HEX_E;
            4'hF:    raw = SEG_HEX_F;
            default: raw = SEG_BLANK;
        endcase
    end

    // Route the table entry through the named segment positions of the output bus.
    always_comb begin
        seg = seg_pack(raw[SEG_A], raw[SEG_B], raw[SEG_C], raw[SEG_D],
                       raw[SEG_E], raw[SEG_F], raw[SEG_G]);
    end

endmodule

// File: rtl/hex_to_seg.sv
// hex_to_seg: registered hex-to-seven-segment decoder; define HEX_TO_SEG_ACTIVE_LOW_EN for common-anode (inverted) outputs
module hex_to_seg
    import hex_to_seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hex,
    input  logic       blank,
    output logic [6:0] segs
);

`ifdef HEX_TO_SEG_ACTIVE_LOW_EN
    localparam seg_t SEG_OFF = ~SEG_BLANK;
`else
    localparam seg_t SEG_OFF = SEG_BLANK;
`endif

    seg_t lut_seg;
    seg_t segs_d;
    seg_t segs_q;

    hex_to_seg_lut u_lut (
        .hex (hex),
        .seg (lut_seg)
    );

    // Blank override and pad polarity are resolved ahead of the register so latency stays one cycle.
    always_comb begin
`ifdef HEX_TO_SEG_ACTIVE_LOW_EN
        segs_d = blank ? SEG_OFF : ~lut_seg;
`else
        segs_d = blank ? SEG_OFF : lut_seg;
`endif
    end

    // Output register keeps pad-facing segment drives glitch-free; reset forces the off pattern.
    always_ff @(posedge clk) begin
        if (rst) segs_q <= SEG_OFF;
        else     segs_q <= segs_d;
    end

    assign segs = segs_q;

endmodule

// File: tb/tb_hex_to_seg.sv
// tb_hex_to_seg: directed self-checking bench for hex_to_seg (honours HEX_TO_SEG_ACTIVE_LOW_EN)
module tb_hex_to_seg;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hex;
    logic       blank;
    logic [6:0] segs;

    int passed = 0;
    int total  = 0;

    logic [6:0] table_ah [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    hex_to_seg dut (
        .clk   (clk),
        .rst   (rst),
        .hex   (hex),
        .blank (blank),
        .segs  (segs)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pol(input logic [6:0] v);
`ifdef HEX_TO_SEG_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        total++;
        assert (segs === exp) passed++;
        else $error("FAIL %s: segs=%h expected=%h", tag, segs, exp);
    endtask

    task automatic step(input logic r, input logic b, input logic [3:0] h);
        rst   = r;
        blank = b;
        hex   = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; blank = 1'b0; hex = 4'h8;
        step(1'b1, 1'b0, 4'h8);
        check("reset_edge1", pol(7'h00));
        step(1'b1, 1'b0, 4'h8);
        check("reset_edge2", pol(7'h00));
        step(1'b0, 1'b0, 4'h8);
        check("reset_release", pol(7'h7F));

        for (int i = 0; i < 16; i++) begin
            if (i == 12) begin
                step(1'b1, 1'b0, 4'(i));
                check("midstream_rst", pol(7'h00));
            end
            step(1'b0, 1'b0, 4'(i));
            check($sformatf("sweep_%0h", i), pol(table_ah[i]));
        end

        step(1'b0, 1'b1, 4'h3);
        check("blank_on", pol(7'h00));
        step(1'b0, 1'b0, 4'h3);
        check("blank_off", pol(7'h4F));

        step(1'b0, 1'b0, 4'h5);
        check("latency_5", pol(7'h6D));
        hex = 4'h6;
        #3;
        check("latency_hold", pol(7'h6D));
        @(posedge clk);
        #1;
        check("latency_6", pol(7'h7D));
        step(1'b0, 1'b0, 4'h6);
        check("hold_const", pol(7'h7D));

        step(1'b1, 1'b1, 4'h2);
        check("rst_and_blank", pol(7'h00));
        step(1'b0, 1'b0, 4'h0);
        check("digit0", pol(7'h3F));
        step(1'b0, 1'b0, 4'h2);
        check("digit2", pol(7'h5B));
        step(1'b0, 1'b1, 4'h2);
        check("blank_again", pol(7'h00));
        step(1'b0, 1'b0, 4'hF);
        check("digitF", pol(7'h71));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
